// File: rtl/mitchel.sv
// Unsigned 9x9 approximate multiplier using Mitchell's logarithmic method.
// Leading-one detect, log-domain add, antilog by shift; product registered once.
module mitchel (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    output logic [16:0] p
);

    function automatic logic [3:0] lead_one(input logic [8:0] v);
        lead_one = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) lead_one = 4'(i);
        end
    endfunction

    // Bits below the leading one, left-aligned into an 8-bit fraction.
    function automatic logic [7:0] frac_of(input logic [8:0] v, input logic [3:0] k);
        logic [16:0] sh;
        sh = {8'd0, v} << (4'd8 - k);
        frac_of = sh[7:0];
    endfunction

    logic [3:0]  kx, ky;
    logic [7:0]  fx, fy;
    logic [8:0]  s;
    logic [4:0]  ksum;
    logic [4:0]  e;
    logic [8:0]  mant;
    logic [17:0] mant_w;
    logic [17:0] res;
    logic [16:0] p_next;

    always_comb begin
        kx     = lead_one(x);
        ky     = lead_one(y);
        fx     = frac_of(x, kx);
        fy     = frac_of(y, ky);
        s      = {1'b0, fx} + {1'b0, fy};
        ksum   = {1'b0, kx} + {1'b0, ky};
        e      = ksum + {4'd0, s[8]};
        mant   = {1'b1, s[7:0]};
        mant_w = {9'd0, mant};
        // floor(mant * 2^e / 256), split so the discarded LSBs never need storing
        if (e >= 5'd8)
            res = mant_w << (e - 5'd8);
        else
            res = mant_w >> (5'd8 - e);

        if (x == 9'd0 || y == 9'd0)
            p_next = 17'd0;
        else if (res[17])
            p_next = 17'h1FFFF;
        else
            p_next = res[16:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            p <= 17'd0;
        else
            p <= p_next;
    end

endmodule

// File: tb/tb_mitchel.sv
// Self-checking bench for mitchel: directed corner cases plus random vectors
// against an arithmetic model of Mitchell's approximation.
module tb_mitchel;

    logic        clk;
    logic        rst;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [16:0] p;

    int errors = 0;
    int checks = 0;

    mitchel dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .p   (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mitchell product from integer identities:
    //   no carry: 2^ky*x + 2^kx*y - 2^(kx+ky)
    //   carry   : 2*(2^ky*x + 2^kx*y - 2^(kx+ky+1))
    function automatic longint model(input int a, input int b);
        int     ka, kb;
        longint t, base, r;
        if (a == 0 || b == 0) return 0;
        ka = $clog2(a + 1) - 1;
        kb = $clog2(b + 1) - 1;
        base = longint'(1) << (ka + kb);
        t = (longint'(a) << kb) + (longint'(b) << ka) - base;
        if (t - base >= base)
            r = 2 * (t - base);
        else
            r = t;
        if (r > 131071) r = 131071;
        return r;
    endfunction

    task automatic step(input int a, input int b);
        x = 9'(a);
        y = 9'(b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(255, 255);
            checks++;
            if (p !== 17'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: p=%0d expected 0", i, p);
            end
        end
        rst = 1'b0;
        step(255, 255);
        checks++;
        if (p !== 17'd65024) begin
            errors++;
            $display("FAIL reset_release: p=%0d expected 65024", p);
        end
    endtask

    task automatic test_directed();
        int va[8] = '{1, 16, 0, 200, 3, 100, 255, 511};
        int vb[8] = '{1, 32, 200, 0, 3, 7, 255, 511};
        int ve[8] = '{1, 512, 0, 0, 8, 672, 65024, 131071};
        for (int i = 0; i < 8; i++) begin
            step(va[i], vb[i]);
            checks++;
            if (p !== 17'(ve[i])) begin
                errors++;
                $display("FAIL directed x=%0d y=%0d: p=%0d expected %0d", va[i], vb[i], p, ve[i]);
            end
        end
    endtask

    task automatic test_power_of_two();
        for (int i = 0; i < 200; i++) begin
            int a, b;
            a = 1 << $urandom_range(0, 8);
            b = $urandom_range(1, 255);
            if (i % 2 == 1) begin
                int t;
                t = a; a = b; b = t;
            end
            step(a, b);
            checks++;
            if (p !== 17'(a * b)) begin
                errors++;
                $display("FAIL pow2_exact x=%0d y=%0d: p=%0d expected %0d", a, b, p, a * b);
            end
        end
    endtask

    task automatic test_back_to_back();
        int va[3] = '{3, 100, 16};
        int vb[3] = '{3, 7, 32};
        int ve[3] = '{8, 672, 512};
        for (int i = 0; i < 3; i++) begin
            step(va[i], vb[i]);
            checks++;
            if (p !== 17'(ve[i])) begin
                errors++;
                $display("FAIL back_to_back step %0d: p=%0d expected %0d", i, p, ve[i]);
            end
        end
        // reset wins over a valid datapath result, then the stream resumes
        rst = 1'b1;
        step(100, 7);
        checks++;
        if (p !== 17'd0) begin
            errors++;
            $display("FAIL reset_priority: p=%0d expected 0", p);
        end
        rst = 1'b0;
        step(3, 3);
        checks++;
        if (p !== 17'd8) begin
            errors++;
            $display("FAIL after_reset: p=%0d expected 8", p);
        end
    endtask

    task automatic test_random_8bit();
        real    rel_sum = 0.0;
        int     n_rel = 0;
        int     bad_model = 0;
        int     bad_over = 0;
        int     bad_bound = 0;
        real    mean;
        for (int i = 0; i < 20000; i++) begin
            int     a, b;
            longint exact, m;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            step(a, b);
            exact = longint'(a) * b;
            m = model(a, b);
            checks++;
            if (longint'(p) != m) begin
                errors++;
                if (bad_model < 5)
                    $display("FAIL rand8_model x=%0d y=%0d: p=%0d expected %0d", a, b, p, m);
                bad_model++;
            end
            checks++;
            if (longint'(p) > exact) begin
                errors++;
                if (bad_over < 5)
                    $display("FAIL rand8_overestimate x=%0d y=%0d: p=%0d exceeds exact %0d", a, b, p, exact);
                bad_over++;
            end
            checks++;
            if (100 * (exact - longint'(p)) > 12 * exact) begin
                errors++;
                if (bad_bound < 5)
                    $display("FAIL rand8_err_bound x=%0d y=%0d: p=%0d exact %0d", a, b, p, exact);
                bad_bound++;
            end
            if (exact != 0) begin
                rel_sum += real'(exact - longint'(p)) / real'(exact);
                n_rel++;
            end
        end
        mean = (n_rel > 0) ? rel_sum / n_rel : 0.0;
        checks++;
        if (mean < 0.030 || mean > 0.046) begin
            errors++;
            $display("FAIL rand8_mean_rel_err: mean=%f expected about 0.038", mean);
        end
    endtask

    task automatic test_random_9bit();
        int bad = 0;
        for (int i = 0; i < 5000; i++) begin
            int     a, b;
            longint m;
            a = $urandom_range(0, 511);
            b = $urandom_range(0, 511);
            step(a, b);
            m = model(a, b);
            checks++;
            if (longint'(p) != m) begin
                errors++;
                if (bad < 5)
                    $display("FAIL rand9_model x=%0d y=%0d: p=%0d expected %0d", a, b, p, m);
                bad++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        x = '0;
        y = '0;
        test_reset();
        test_directed();
        test_power_of_two();
        test_back_to_back();
        test_random_8bit();
        test_random_9bit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
